// File: rtl/microtile_add_sched.sv
// Two-requester round-robin scheduler feeding a 4-bit + 4-bit adder.
// Flow: IDLE grants a winner, COMPUTE forms the sum, RESULT holds it
// until the consumer accepts. Every output comes straight from a flop.
module microtile_add_sched #(
  parameter int unsigned SUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [3:0]       opa0,
  input  logic [3:0]       opb0,
  input  logic [3:0]       opa1,
  input  logic [3:0]       opb1,
  output logic [1:0]       gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUM_W-1:0] res_sum,
  output logic             res_id,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompute = 2'd1,
    StResult  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             win_q, win_d;
  logic [3:0]       op_a_q, op_a_d;
  logic [3:0]       op_b_q, op_b_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             res_valid_q, res_valid_d;
  logic [SUM_W-1:0] res_sum_q, res_sum_d;
  logic             res_id_q, res_id_d;
  logic             busy_q, busy_d;
  logic [7:0]       done_cnt_q, done_cnt_d;

  logic             arb_win;
  logic [4:0]       sum5;

  // Lone requester wins outright; on contention the pointer decides.
  always_comb begin
    unique case (req)
      2'b01:   arb_win = 1'b0;
      2'b10:   arb_win = 1'b1;
      default: arb_win = ptr_q;
    endcase
  end

  // 5-bit sum keeps the carry of 15 + 15.
  assign sum5 = {1'b0, op_a_q} + {1'b0, op_b_q};

  // Next-state and next-output logic for the three-phase transaction.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    gnt_d       = 2'b00;
    res_valid_d = res_valid_q;
    res_sum_d   = res_sum_q;
    res_id_d    = res_id_q;
    done_cnt_d  = done_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (req != 2'b00) begin
          win_d   = arb_win;
          op_a_d  = arb_win ? opa1 : opa0;
          op_b_d  = arb_win ? opb1 : opb0;
          gnt_d   = arb_win ? 2'b10 : 2'b01;
          // Loser gets priority next time.
          ptr_d   = ~arb_win;
          state_d = StCompute;
        end
      end
      StCompute: begin
        res_sum_d   = SUM_W'(sum5);
        res_id_d    = win_q;
        res_valid_d = 1'b1;
        state_d     = StResult;
      end
      StResult: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + 8'd1;
          state_d     = StIdle;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase

    // Registered from the next state so busy lines up with the state flop.
    busy_d = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      win_q       <= 1'b0;
      op_a_q      <= 4'd0;
      op_b_q      <= 4'd0;
      gnt_q       <= 2'b00;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_id_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_sum_q   <= res_sum_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;
  assign done_cnt  = done_cnt_q;

endmodule
